// File: rtl/act_stream_collector.sv
// Receive end of the activation pipe: packs result bytes into LANES-byte words,
// buffers them in a fall-through FIFO and meters issue credits back to the feeder.
module act_stream_collector #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_INFL   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_vld,
    output logic                 issue_rdy,
    input  logic                 act_vld,
    input  logic [7:0]           act_data,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    output logic                 err_ovf
);

    localparam int unsigned CAP = FIFO_DEPTH * LANES;
    localparam int unsigned CW  = $clog2(CAP + 1);
    localparam int unsigned IW  = $clog2(MAX_INFL + 1);
    localparam int unsigned LW  = $clog2(LANES);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } flush_state_e;

    flush_state_e            state_q, state_d;
    logic [CW-1:0]           credits_q, credits_d;
    logic [IW-1:0]           inflight_q, inflight_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic [8*LANES-1:0]      pack_q, pack_d;
    logic                    err_q, err_d;

    logic [8*LANES-1:0]      mem_data_q [FIFO_DEPTH];
    logic [LANES-1:0]        mem_keep_q [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [FW-1:0]           fifo_cnt_q, fifo_cnt_d;

    logic                    issue_acc, pop, drained, flush_fire;
    logic                    full_push, part_push, push, push_ok, drop;
    logic [8*LANES-1:0]      merged;
    logic [LW:0]             fill_cnt;
    logic [LANES-1:0]        push_keep;
    logic [LW+2:0]           lane_base;
    int                      cred_raw, infl_raw;

    assign issue_rdy = (credits_q != '0) && !flush_req && !rst;
    assign issue_acc = issue_vld && issue_rdy;
    assign out_vld   = (fifo_cnt_q != '0);
    assign pop       = out_vld && out_rdy;
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_keep  = mem_keep_q[rd_ptr_q];
    assign err_ovf   = err_q;

    // A result arriving in the same cycle as the last in-flight one still counts as drained.
    assign drained = (inflight_q == '0) || ((inflight_q == IW'(1)) && act_vld);

    // Flush FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Flush FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (flush_req) state_d = S_WAIT;
            S_WAIT: if (!flush_req || drained) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Flush FSM: outputs
    always_comb begin
        flush_fire = (state_q == S_WAIT) && flush_req && drained;
        flush_done = flush_fire;
    end

    always_comb begin
        lane_base = {cnt_q, 3'b000};
        merged    = pack_q;
        if (act_vld) merged[lane_base +: 8] = act_data;
        fill_cnt  = {1'b0, cnt_q} + {{LW{1'b0}}, act_vld};
        full_push = act_vld && (cnt_q == LW'(LANES - 1));
        part_push = flush_fire && !full_push && (fill_cnt != '0);
        push      = full_push || part_push;
        for (int unsigned i = 0; i < LANES; i++) begin
            push_keep[i] = full_push || ((LW+1)'(i) < fill_cnt);
        end
        push_ok   = push && ((fifo_cnt_q != FW'(FIFO_DEPTH)) || pop);
        drop      = push && !push_ok;

        cnt_d  = cnt_q;
        pack_d = merged;
        if (push) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (act_vld) begin
            cnt_d = cnt_q + LW'(1);
        end

        fifo_cnt_d = fifo_cnt_q + FW'(push_ok) - FW'(pop);
        err_d      = err_q || (act_vld && (inflight_q == '0)) || drop;

        cred_raw = int'(credits_q) - int'(issue_acc)
                 + (pop ? int'(LANES) : 0)
                 - (part_push ? (int'(LANES) - int'(fill_cnt)) : 0);
        infl_raw = int'(inflight_q) + int'(issue_acc)
                 - int'(act_vld && (inflight_q != '0));

        // Clamping only matters after an overflow event has already flagged err_ovf.
        if (cred_raw < 0)                credits_d = '0;
        else if (cred_raw > int'(CAP))   credits_d = CW'(CAP);
        else                             credits_d = CW'(cred_raw);
        if (infl_raw > int'(MAX_INFL))   inflight_d = IW'(MAX_INFL);
        else                             inflight_d = IW'(infl_raw);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q  <= CW'(CAP);
            inflight_q <= '0;
            cnt_q      <= '0;
            pack_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            pack_q     <= pack_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_keep_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_data_q[wr_ptr_q] <= merged;
                mem_keep_q[wr_ptr_q] <= push_keep;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        (!err_q && !err_d) |-> (cred_raw >= 0 && cred_raw <= int'(CAP) &&
                                infl_raw >= 0 && infl_raw <= int'(MAX_INFL)));

endmodule

// File: tb/tb_act_stream_collector.sv
// Bench for act_stream_collector: models an 8-deep activation pipe feeding the
// collector and checks popped words against a scoreboard of expected words.
module tb_act_stream_collector;

    localparam int LANES = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, issue_vld, issue_rdy, act_vld, flush_req, flush_done;
    logic        out_vld, out_rdy, err_ovf;
    logic [7:0]  act_data, issue_data;
    logic [63:0] out_data;
    logic [7:0]  out_keep;

    always #5 clk = ~clk;

    act_stream_collector #(.LANES(LANES), .FIFO_DEPTH(DEPTH), .MAX_INFL(16)) dut (
        .clk(clk), .rst(rst), .issue_vld(issue_vld), .issue_rdy(issue_rdy),
        .act_vld(act_vld), .act_data(act_data), .flush_req(flush_req),
        .flush_done(flush_done), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .out_keep(out_keep), .err_ovf(err_ovf)
    );

    typedef struct { logic [63:0] data; logic [7:0] keep; } word_t;
    typedef struct {
        int          n;
        logic [63:0] bytes;
        bit          flush;
        bit          has_word;
        logic [63:0] exp_data;
        logic [7:0]  exp_keep;
    } vec_t;

    word_t       sb[$];
    vec_t        tbl[7];
    int          checks = 0, errors = 0;
    logic        pv[8];
    logic [7:0]  pd[8];
    int          cyc = 0, acts_seen, done_count, last_act_cyc, vld_cyc;
    bit          fd_seen, last_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        word_t w;
        #1;
        cyc++;
        last_acc = issue_vld && issue_rdy;
        if (act_vld) begin
            acts_seen++;
            last_act_cyc = cyc;
        end
        fd_seen = flush_done;
        if (flush_done) done_count++;
        if (out_vld && vld_cyc < 0) vld_cyc = cyc;
        if (out_vld && out_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
                w = sb.pop_front();
                check("word_data", out_data, w.data);
                check("word_keep", 64'(out_keep), 64'(w.keep));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 7; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0]    = last_acc;
        pd[0]    = issue_data;
        act_vld  = pv[7];
        act_data = pv[7] ? pd[7] : 8'h00;
    endtask

    function automatic bit pipe_busy();
        bit b = 1'b0;
        for (int i = 0; i < 8; i++) b |= pv[i];
        return b;
    endfunction

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((sb.size() != 0 || out_vld || pipe_busy()) && k < budget) begin
            step();
            k++;
        end
        if (sb.size() != 0 || out_vld || pipe_busy()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
        end
    endtask

    task automatic issue_bytes(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            issue_vld  = 1'b1;
            issue_data = bytes[8*i +: 8];
            step();
            check("issue_accepted", 64'(last_acc), 64'd1);
        end
        issue_vld = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] d, input logic [7:0] k);
        word_t w;
        w.data = d;
        w.keep = k;
        sb.push_back(w);
    endtask

    task automatic inject(input logic [7:0] d, input logic rdy);
        act_vld  = 1'b1;
        act_data = d;
        out_rdy  = rdy;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          done_k, acc_cnt;
        logic [63:0] wd;

        tbl[0] = '{8, 64'h0807060504030201, 1'b0, 1'b1, 64'h0807060504030201, 8'hFF};
        tbl[1] = '{3, 64'h0000000000CCBBAA, 1'b1, 1'b1, 64'h0000000000CCBBAA, 8'h07};
        tbl[2] = '{0, 64'h0,                1'b1, 1'b0, 64'h0,                8'h00};
        tbl[3] = '{5, 64'h0000001122334455, 1'b1, 1'b1, 64'h0000001122334455, 8'h1F};
        tbl[4] = '{7, 64'h00F0E0D0C0B0A090, 1'b1, 1'b1, 64'h00F0E0D0C0B0A090, 8'h7F};
        tbl[5] = '{1, 64'h000000000000007F, 1'b1, 1'b1, 64'h000000000000007F, 8'h01};
        tbl[6] = '{8, 64'hFEDCBA9876543210, 1'b1, 1'b1, 64'hFEDCBA9876543210, 8'hFF};

        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pd[i] = 8'h00;
        end
        rst = 1'b1; issue_vld = 1'b0; issue_data = 8'h00; act_vld = 1'b0;
        act_data = 8'h00; flush_req = 1'b0; out_rdy = 1'b1;
        step();
        step();
        check("rst_issue_rdy", 64'(issue_rdy), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_err_ovf", 64'(err_ovf), 64'd0);
        check("post_rst_issue_rdy", 64'(issue_rdy), 64'd1);

        // Table-driven bursts with and without flush.
        for (int t = 0; t < 7; t++) begin
            acts_seen = 0; done_count = 0; vld_cyc = -1; last_act_cyc = -1;
            if (tbl[t].has_word) push_word(tbl[t].exp_data, tbl[t].exp_keep);
            out_rdy = 1'b1;
            issue_bytes(tbl[t].bytes, tbl[t].n);
            if (tbl[t].flush) begin
                flush_req = 1'b1;
                done_k = -1;
                for (int k = 1; k <= 30; k++) begin
                    step();
                    if (fd_seen) begin
                        done_k = k;
                        break;
                    end
                end
                flush_req = 1'b0;
                if (done_k < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flush_timeout[%0d]: got no flush_done expected pulse", t);
                end else begin
                    check("flush_acts_before_done", 64'(acts_seen), 64'(tbl[t].n));
                    if (tbl[t].n == 0) check("flush_empty_latency", 64'(done_k), 64'd2);
                end
            end
            wait_idle(60);
            check("flush_pulses", 64'(done_count), 64'(tbl[t].flush ? 1 : 0));
            if (tbl[t].has_word) check("word_latency", 64'(vld_cyc - last_act_cyc), 64'd1);
            check("credits_restored", 64'(dut.credits_q), 64'd32);
            check("pack_cnt_zero", 64'(dut.cnt_q), 64'd0);
        end
        check("no_err_after_table", 64'(err_ovf), 64'd0);

        // Aborted flush: no pulse, no push; bytes stay in the word being built.
        done_count = 0;
        push_word(64'h8877665544332211, 8'hFF);
        issue_bytes(64'h2211, 2);
        flush_req = 1'b1;
        step();
        step();
        flush_req = 1'b0;
        issue_bytes(64'h0000887766554433, 6);
        wait_idle(60);
        check("abort_no_pulse", 64'(done_count), 64'd0);

        // Credit exhaustion with a stalled sink.
        out_rdy = 1'b0; issue_vld = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            issue_data = 8'(acc_cnt + 16);
            step();
            if (last_acc) acc_cnt++;
        end
        issue_vld = 1'b0;
        check("credit_limit", 64'(acc_cnt), 64'd32);
        for (int j = 0; j < 5; j++) begin
            for (int b = 0; b < 8; b++) wd[8*b +: 8] = 8'(16 + 8*j + b);
            if (j < 4) push_word(wd, 8'hFF);
        end
        for (int i = 0; i < 12; i++) step();
        check("full_fifo_cnt", 64'(dut.fifo_cnt_q), 64'd4);
        check("full_out_vld", 64'(out_vld), 64'd1);
        check("full_no_err", 64'(err_ovf), 64'd0);
        check("full_issue_rdy", 64'(issue_rdy), 64'd0);
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        issue_vld = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            issue_data = 8'(acc_cnt + 48);
            step();
            if (last_acc) acc_cnt++;
        end
        issue_vld = 1'b0;
        check("credits_after_pop", 64'(acc_cnt), 64'd8);
        push_word(64'h3736353433323130, 8'hFF);
        for (int i = 0; i < 12; i++) step();
        check("refill_fifo_cnt", 64'(dut.fifo_cnt_q), 64'd4);

        // Word completes on the same edge as a pop while full (injected bytes).
        push_word(64'hA7A6A5A4A3A2A1A0, 8'hFF);
        for (int i = 0; i < 7; i++) inject(8'(8'hA0 + i), 1'b0);
        inject(8'hA7, 1'b1);
        out_rdy = 1'b0;
        check("same_edge_fifo_cnt", 64'(dut.fifo_cnt_q), 64'd4);
        check("inject_err_ovf", 64'(err_ovf), 64'd1);
        out_rdy = 1'b1;
        wait_idle(40);

        // Reset with 2 words buffered and 3 results in flight.
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_rdy = 1'b0;
        issue_bytes(64'h0F0E0D0C0B0A0908, 8);
        issue_bytes(64'h1716151413121110, 8);
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_fifo_cnt", 64'(dut.fifo_cnt_q), 64'd2);
        issue_bytes(64'h00000000003A2A1A, 3);
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_issue_rdy", 64'(issue_rdy), 64'd0);
        step();
        rst = 1'b0;
        sb.delete();
        check("mid_rst_out_vld", 64'(out_vld), 64'd0);
        check("mid_rst_credits", 64'(dut.credits_q), 64'd32);
        check("mid_rst_err", 64'(err_ovf), 64'd0);
        for (int i = 0; i < 10; i++) step();
        check("late_act_err_ovf", 64'(err_ovf), 64'd1);
        check("late_act_no_word", 64'(out_vld), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
